// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if
//   Bundles the next-PC controller's request inputs (hazard unit, D-stage
//   branch logic, CP0, current F_PC) and its fetch-unit outputs.
//   Optional macro FETCH_CTRL_PERF_EN adds the perf_stall_cnt and
//   perf_redir_cnt counter outputs.
//   Modports:
//     master : request side (drives F_PC/stall/br_*/exc_req/eret_req/epc,
//              observes nextPC/F_IFU_en/F_flush/pc_err)
//     slave  : the controller itself
interface fetch_pc_ctrl_if;
    logic [31:0] F_PC;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] nextPC;
    logic        F_IFU_en;
    logic        F_flush;
    logic        pc_err;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redir_cnt;
`endif

    modport master (
        output F_PC, stall, br_valid, br_target, exc_req, eret_req, epc,
        input  nextPC, F_IFU_en, F_flush,
`ifdef FETCH_CTRL_PERF_EN
        input  perf_stall_cnt, perf_redir_cnt,
`endif
        input  pc_err
    );

    modport slave (
        input  F_PC, stall, br_valid, br_target, exc_req, eret_req, epc,
        output nextPC, F_IFU_en, F_flush,
`ifdef FETCH_CTRL_PERF_EN
        output perf_stall_cnt, perf_redir_cnt,
`endif
        output pc_err
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
//   Next-PC sequencer for the F stage. Selects nextPC from PC+4, a D-stage
//   redirect, the exception vector or the eret return address, and drives
//   the fetch-unit PC write enable. A redirect seen while stalled is held
//   and issued when the stall releases. Outputs are combinational.
//   Ports:
//     clk    : clock, all state on posedge
//     reset  : synchronous, active-high
//     bus    : fetch_pc_ctrl_if.slave (requests in, nextPC/F_IFU_en/
//              F_flush/pc_err out)
//   Optional macro FETCH_CTRL_PERF_EN: saturating stall / redirect counters.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   RUN      | no pending redirect
//   HOLD_RED | stalled with a redirect target latched in pend_tgt
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6ffc
) (
    input logic           clk,
    input logic           reset,
    fetch_pc_ctrl_if.slave bus
);
    typedef enum logic {RUN, HOLD_RED} state_t;

    state_t      state, state_n;
    logic [31:0] pend_tgt, pend_n;
    logic [31:0] next_pc;
    logic [31:0] eret_pc;
    logic        en, flush, redir;

    assign eret_pc = bus.epc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pend_tgt <= '0;
        end else begin
            state    <= state_n;
            pend_tgt <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend_tgt;
        next_pc = bus.F_PC + 32'd4;
        en      = 1'b0;
        flush   = 1'b0;
        redir   = 1'b0;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (bus.exc_req) begin
            next_pc = EXC_VEC;
            en      = 1'b1;
            flush   = 1'b1;
            redir   = 1'b1;
            state_n = RUN;
        end else if (bus.eret_req) begin
            next_pc = eret_pc;
            en      = 1'b1;
            flush   = 1'b1;
            redir   = 1'b1;
            state_n = RUN;
        end else if (state == HOLD_RED) begin
            if (!bus.stall) begin
                // br_valid here is the same branch already latched
                next_pc = pend_tgt;
                en      = 1'b1;
                redir   = 1'b1;
                state_n = RUN;
            end else if (bus.br_valid) begin
                pend_n = bus.br_target;
            end
        end else if (bus.br_valid) begin
            if (!bus.stall) begin
                // F holds the delay slot, so no flush
                next_pc = bus.br_target;
                en      = 1'b1;
                redir   = 1'b1;
            end else begin
                pend_n  = bus.br_target;
                state_n = HOLD_RED;
            end
        end else begin
            en = !bus.stall;
        end
    end

    assign bus.nextPC   = next_pc;
    assign bus.F_IFU_en = en;
    assign bus.F_flush  = flush;
    assign bus.pc_err   = en & ((next_pc[1:0] != 2'b00) | (next_pc < PC_LO) | (next_pc > PC_HI));

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt, redir_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (!en && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (redir && redir_cnt != 32'hFFFF_FFFF) redir_cnt <= redir_cnt + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_redir_cnt = redir_cnt;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] fpc;
        logic        stall;
        logic        brv;
        logic [31:0] brt;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        en;
        logic        fl;
        logic        err;
        logic        chkpc;
    } exp_t;

    exp_t sb[$];

    function automatic stim_t mk_s(logic rst, logic [31:0] fpc, logic stall, logic brv,
                                   logic [31:0] brt, logic exc, logic eret, logic [31:0] epc);
        stim_t s;
        s.rst = rst; s.fpc = fpc; s.stall = stall; s.brv = brv;
        s.brt = brt; s.exc = exc; s.eret = eret; s.epc = epc;
        return s;
    endfunction

    function automatic exp_t mk_e(string name, logic [31:0] pc, logic en, logic fl,
                                  logic err, logic chkpc);
        exp_t e;
        e.name = name; e.pc = pc; e.en = en; e.fl = fl; e.err = err; e.chkpc = chkpc;
        return e;
    endfunction

    // Applies one cycle of stimulus just after the rising edge.
    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        reset         = s.rst;
        bus.F_PC      = s.fpc;
        bus.stall     = s.stall;
        bus.br_valid  = s.brv;
        bus.br_target = s.brt;
        bus.exc_req   = s.exc;
        bus.eret_req  = s.eret;
        bus.epc       = s.epc;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(1, 32'h3000, 0, 0, 0, 0, 0, 0)); x.push_back(mk_e("reset_c1", 32'h3000, 0, 0, 0, 1));
        s.push_back(mk_s(1, 32'h3000, 0, 0, 0, 0, 0, 0)); x.push_back(mk_e("reset_c2", 32'h3000, 0, 0, 0, 1));
        s.push_back(mk_s(1, 32'h3000, 0, 1, 32'h5000, 1, 0, 0)); x.push_back(mk_e("reset_masks_req", 32'h3000, 0, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3000, 0, 0, 0, 0, 0, 0)); x.push_back(mk_e("reset_release", 32'h3004, 1, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(0, 32'h3010, 0, 1, 32'h3040, 0, 0, 0)); x.push_back(mk_e("br_taken", 32'h3040, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3040, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("br_after", 32'h3044, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3044, 1, 0, 0, 0, 0, 0));        x.push_back(mk_e("plain_stall", 32'h3048, 0, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(1, 32'h3000, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("sr_reset", 32'h3000, 0, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3040, 1, 1, 32'h3080, 0, 0, 0)); x.push_back(mk_e("sr_stall1", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3040, 1, 0, 0, 0, 0, 0));        x.push_back(mk_e("sr_stall2", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3040, 1, 0, 0, 0, 0, 0));        x.push_back(mk_e("sr_stall3", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3044, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("sr_release", 32'h3080, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3080, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("sr_seq", 32'h3084, 1, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
`ifdef FETCH_CTRL_PERF_EN
        total++;
        if (bus.perf_stall_cnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_stall_cnt: got %0d want 3", bus.perf_stall_cnt);
        end
        total++;
        if (bus.perf_redir_cnt !== 32'd1) begin
            bad++;
            $display("FAIL perf_redir_cnt: got %0d want 1", bus.perf_redir_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(0, 32'h3100, 1, 1, 32'h3200, 0, 0, 0)); x.push_back(mk_e("lw_first", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3100, 1, 1, 32'h3300, 0, 0, 0)); x.push_back(mk_e("lw_second", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3104, 0, 1, 32'h3400, 0, 0, 0)); x.push_back(mk_e("lw_release", 32'h3300, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3300, 0, 1, 32'h3500, 0, 0, 0)); x.push_back(mk_e("br_after_rel", 32'h3500, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3500, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("b2b_seq", 32'h3504, 1, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    task automatic test_exception();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(0, 32'h3040, 1, 1, 32'h3080, 0, 0, 0)); x.push_back(mk_e("exc_hold", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3040, 1, 0, 0, 1, 0, 0));        x.push_back(mk_e("exc_taken", 32'h4180, 1, 1, 0, 1));
        s.push_back(mk_s(0, 32'h4180, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("exc_next", 32'h4184, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h4184, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("exc_no_pend", 32'h4188, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3040, 1, 1, 32'h3080, 0, 0, 0)); x.push_back(mk_e("eret_hold", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3040, 1, 0, 0, 0, 1, 32'h3600)); x.push_back(mk_e("eret_drops_pend", 32'h3600, 1, 1, 0, 1));
        s.push_back(mk_s(0, 32'h3600, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("eret_next", 32'h3604, 1, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    task automatic test_eret();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(0, 32'h3010, 0, 0, 0, 1, 1, 32'h3024)); x.push_back(mk_e("exc_over_eret", 32'h4180, 1, 1, 0, 1));
        s.push_back(mk_s(0, 32'h4180, 0, 0, 0, 0, 1, 32'h3027)); x.push_back(mk_e("eret_align", 32'h3024, 1, 1, 0, 1));
        s.push_back(mk_s(0, 32'h3024, 1, 0, 0, 0, 1, 32'h3030)); x.push_back(mk_e("eret_ign_stall", 32'h3030, 1, 1, 0, 1));
        s.push_back(mk_s(0, 32'h3030, 1, 0, 0, 1, 0, 0));        x.push_back(mk_e("exc_ign_stall", 32'h4180, 1, 1, 0, 1));
        s.push_back(mk_s(0, 32'h4180, 0, 1, 32'h3090, 0, 1, 32'h3050)); x.push_back(mk_e("eret_over_br", 32'h3050, 1, 1, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    task automatic test_pc_err();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(0, 32'h3010, 0, 1, 32'h7000, 0, 0, 0));  x.push_back(mk_e("err_above", 32'h7000, 1, 0, 1, 1));
        s.push_back(mk_s(0, 32'h3010, 0, 1, 32'h3042, 0, 0, 0));  x.push_back(mk_e("err_misalign", 32'h3042, 1, 0, 1, 1));
        s.push_back(mk_s(0, 32'h3010, 0, 1, 32'h6ffc, 0, 0, 0));  x.push_back(mk_e("ok_pc_hi", 32'h6ffc, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h2ffc, 0, 0, 0, 0, 0, 0));         x.push_back(mk_e("ok_pc_lo", 32'h3000, 1, 0, 0, 1));
        s.push_back(mk_s(0, 32'h2ff8, 0, 0, 0, 0, 0, 0));         x.push_back(mk_e("err_below", 32'h2ffc, 1, 0, 1, 1));
        s.push_back(mk_s(0, 32'hffff_fffc, 0, 0, 0, 0, 0, 0));    x.push_back(mk_e("wrap", 32'h0, 1, 0, 1, 1));
        s.push_back(mk_s(0, 32'h7000, 1, 0, 0, 0, 0, 0));         x.push_back(mk_e("err_masked_en0", 32'h7004, 0, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3000, 1, 1, 32'h3043, 0, 0, 0));  x.push_back(mk_e("mis_hold", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(0, 32'h3000, 0, 0, 0, 0, 0, 0));         x.push_back(mk_e("mis_release", 32'h3043, 1, 0, 1, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    task automatic test_reset_discards();
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        s.push_back(mk_s(0, 32'h3000, 1, 1, 32'h3800, 0, 0, 0)); x.push_back(mk_e("rd_hold", 32'h0, 0, 0, 0, 0));
        s.push_back(mk_s(1, 32'h3000, 1, 0, 0, 0, 0, 0));        x.push_back(mk_e("rd_reset", 32'h3000, 0, 0, 0, 1));
        s.push_back(mk_s(0, 32'h3000, 0, 0, 0, 0, 0, 0));        x.push_back(mk_e("rd_no_pend", 32'h3004, 1, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (bus.F_IFU_en !== e.en || bus.F_flush !== e.fl || bus.pc_err !== e.err ||
                (e.chkpc && bus.nextPC !== e.pc)) begin
                bad++;
                $display("FAIL %s: got nextPC=%h en=%b flush=%b err=%b, want nextPC=%h en=%b flush=%b err=%b",
                         e.name, bus.nextPC, bus.F_IFU_en, bus.F_flush, bus.pc_err, e.pc, e.en, e.fl, e.err);
            end
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.F_PC      = 32'h3000;
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_target = '0;
        bus.exc_req   = 1'b0;
        bus.eret_req  = 1'b0;
        bus.epc       = '0;
        test_reset();
        test_branch();
        test_stall_redirect();
        test_back_to_back();
        test_exception();
        test_eret();
        test_pc_err();
        test_reset_discards();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
